// File: rtl/wb_mport_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// Define WB_ARB_TIMEOUT_EN to abort strobes the slave leaves unanswered for TIMEOUT cycles.
module wb_mport_arbiter #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                          wb_clk,
  input  logic                          wb_rst_n,
  input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
  input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
  input  logic [NUM_MASTERS-1:0]        wbm_we_i,
  output logic [DW-1:0]                 wbm_dat_o,
  output logic [NUM_MASTERS-1:0]        wbm_ack_o,
  output logic [NUM_MASTERS-1:0]        wbm_err_o,
  output logic [NUM_MASTERS-1:0]        wbm_rty_o,
  output logic [AW-1:0]                 wbs_adr_o,
  output logic [DW-1:0]                 wbs_dat_o,
  output logic [DW/8-1:0]               wbs_sel_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic                          wbs_we_o,
  input  logic [DW-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = $clog2(NUM_MASTERS);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
`ifdef WB_ARB_TIMEOUT_EN
  localparam logic [1:0] StTmo   = 2'd2;
`endif

  if (NUM_MASTERS < 2 || NUM_MASTERS > 8) begin : g_bad_num_masters
    $error("NUM_MASTERS must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("TIMEOUT must be in 1..65535");
  end

  logic [1:0]             state_q, state_d;
  logic [IW-1:0]          gidx_q, gidx_d;
  logic [IW-1:0]          last_q, last_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          pick;
  logic                   found;
  int unsigned            cand;
`ifdef WB_ARB_TIMEOUT_EN
  logic [15:0]            cnt_q, cnt_d;
  logic                   waiting;
`endif

  // Search starts just after the last owner so every requester gets a turn.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    cand  = 0;
    for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
      cand = (32'(last_q) + k) % NUM_MASTERS;
      if (!found && wbm_cyc_i[cand]) begin
        found = 1'b1;
        pick  = cand[IW-1:0];
      end
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  assign waiting = wbs_stb_o && !(wbs_ack_i || wbs_err_i || wbs_rty_i);
`endif

  always_comb begin
    state_d = state_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    grant_d = grant_q;
`ifdef WB_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d       = StGrant;
          gidx_d        = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      StGrant: begin
        if (!wbm_cyc_i[gidx_q]) begin
          state_d = StIdle;
          last_d  = gidx_q;
          grant_d = '0;
`ifdef WB_ARB_TIMEOUT_EN
          cnt_d   = '0;
        end else if (waiting) begin
          if (cnt_q == 16'(TIMEOUT - 1)) begin
            state_d = StTmo;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end else begin
          cnt_d = '0;
`endif
        end
      end
`ifdef WB_ARB_TIMEOUT_EN
      StTmo: begin
        state_d = StIdle;
        last_d  = gidx_q;
        grant_d = '0;
      end
`endif
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  // Slave side is gated by the registered state, so an async reset silences it at once.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_we_o  = 1'b0;
    wbm_ack_o = '0;
    wbm_err_o = '0;
    wbm_rty_o = '0;
    if (state_q == StGrant) begin
      wbs_adr_o         = wbm_adr_i[gidx_q*AW +: AW];
      wbs_dat_o         = wbm_dat_i[gidx_q*DW +: DW];
      wbs_sel_o         = wbm_sel_i[gidx_q*SW +: SW];
      wbs_cti_o         = wbm_cti_i[gidx_q*3 +: 3];
      wbs_bte_o         = wbm_bte_i[gidx_q*2 +: 2];
      wbs_cyc_o         = wbm_cyc_i[gidx_q];
      wbs_stb_o         = wbm_stb_i[gidx_q];
      wbs_we_o          = wbm_we_i[gidx_q];
      wbm_ack_o[gidx_q] = wbs_ack_i;
      wbm_err_o[gidx_q] = wbs_err_i;
      wbm_rty_o[gidx_q] = wbs_rty_i;
    end
`ifdef WB_ARB_TIMEOUT_EN
    if (state_q == StTmo) begin
      wbm_err_o[gidx_q] = 1'b1;
    end
`endif
  end

  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant_q;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q <= StIdle;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_MASTERS - 1);
      grant_q <= '0;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      grant_q <= grant_d;
`ifdef WB_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule
